// File: rtl/kmeans_div_pkg.sv
// Shared types and half-precision constants for the k-means divider scheduler.
// The special-case classifier lives here so the scheduler and any neighbouring logic agree on it.
package kmeans_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [15:0] HP_QNAN  = 16'h7E00;
    localparam logic [15:0] HP_INF   = 16'h7C00;
    localparam int          EXP_BIAS = 15;
    localparam int          EXP_MAX  = 31;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
        logic        special;
    } sc_t;

    // Cases the divider cannot handle, in priority order: NaN/Inf or 0/0, x/0, 0/x.
    function automatic sc_t special_case(input logic [15:0] num, input logic [15:0] den);
        sc_t        r;
        logic       sgn;
        logic [4:0] en;
        logic [4:0] ed;
        sgn = num[15] ^ den[15];
        en  = num[14:10];
        ed  = den[14:10];
        r   = '0;
        if (en == 5'(EXP_MAX) || ed == 5'(EXP_MAX) || (en == 5'd0 && ed == 5'd0)) begin
            r = '{data: HP_QNAN, err: 1'b1, special: 1'b1};
        end else if (ed == 5'd0) begin
            r = '{data: {sgn, HP_INF[14:0]}, err: 1'b1, special: 1'b1};
        end else if (en == 5'd0) begin
            r = '{data: {sgn, 15'b0}, err: 1'b0, special: 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/kmeans_div_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
// The pointer advances past the winner only when adv is high and someone won.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           adv,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW:0]   cand;
    logic           found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDW-1:0];
            end
        end
        if (found) gnt[idx] = 1'b1;
        ptr_d = ptr_q;
        if (adv && found) ptr_d = (int'(idx) == N-1) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/kmeans_div_scheduler.sv
// Shares one approximate half-precision divider among N centroid lanes.
// Handles sign, special values and exponent range around the divider, returns tagged quotients.
module kmeans_div_scheduler
    import kmeans_div_pkg::*;
#(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [16*N-1:0]   req_num,
    input  logic [16*N-1:0]   req_den,
    output logic [N-1:0]      gnt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_data,
    output logic              rsp_err,
    output logic [15:0]       div_in1,
    output logic [15:0]       div_in2,
    output logic              div_en,
    input  logic [15:0]       div_out,
    input  logic              div_done
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t         state_q, state_d;
    logic [14:0]    num_q, num_d, den_q, den_d;
    logic [IDW-1:0] id_q, id_d;
    logic           sign_q, sign_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           div_en_q, div_en_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_err_q, rsp_err_d;
    logic [15:0]    rsp_data_q, rsp_data_d;

    logic [N-1:0]   arb_gnt;
    logic [IDW-1:0] arb_idx;
    logic           in_idle;
    logic [15:0]    win_num, win_den;
    sc_t            sc;
    logic [6:0]     ex;
    logic           ex_low, ex_high;

    // Grants are combinational so operands are latched in the same cycle gnt is seen.
    assign in_idle = (state_q == ST_IDLE) && !rst;

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (in_idle ? req : '0),
        .adv (in_idle),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        win_num = '0;
        win_den = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_gnt[i]) begin
                win_num = req_num[16*i +: 16];
                win_den = req_den[16*i +: 16];
            end
        end
    end

    assign sc      = special_case(win_num, win_den);
    assign ex      = 7'({2'b0, num_q[14:10]}) - 7'({2'b0, den_q[14:10]}) + 7'(EXP_BIAS);
    assign ex_low  = ex[6] || (ex == 7'd0);
    assign ex_high = !ex[6] && (ex >= 7'(EXP_MAX));

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        den_d       = den_q;
        id_d        = id_q;
        sign_d      = sign_q;
        cnt_d       = cnt_q;
        div_en_d    = div_en_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    num_d  = win_num[14:0];
                    den_d  = win_den[14:0];
                    id_d   = arb_idx;
                    sign_d = win_num[15] ^ win_den[15];
                    cnt_d  = CW'(TIMEOUT - 1);
                    if (sc.special) begin
                        rsp_data_d  = sc.data;
                        rsp_err_d   = sc.err;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        div_en_d = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (div_done) begin
                    div_en_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                    rsp_err_d   = 1'b0;
                    if (ex_low) begin
                        rsp_data_d = {sign_q, 15'b0};
                    end else if (ex_high) begin
                        rsp_data_d = {sign_q, HP_INF[14:0]};
                        rsp_err_d  = 1'b1;
                    end else begin
                        rsp_data_d = {sign_q, 15'b0} | (div_out & 16'h7FFF);
                    end
                end else if (cnt_q == '0) begin
                    div_en_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = HP_QNAN;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            den_q       <= '0;
            id_q        <= '0;
            sign_q      <= 1'b0;
            cnt_q       <= '0;
            div_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            den_q       <= den_d;
            id_q        <= id_d;
            sign_q      <= sign_d;
            cnt_q       <= cnt_d;
            div_en_q    <= div_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign gnt       = in_idle ? arb_gnt : '0;
    assign div_en    = div_en_q;
    assign div_in1   = {1'b0, num_q};
    assign div_in2   = {1'b0, den_q};
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
